// File: rtl/fwrisc_csr_sequencer_if.sv
// Request-side handshake between the pipeline's system-instruction decode
// (master) and the CSR read-modify-write sequencer (slave).
interface fwrisc_csr_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [5:0]  req_csr;
    logic [5:0]  req_rd;
    logic [31:0] req_src;
    logic        req_wsup;
    logic        done;
    logic        illegal;

    modport master (
        output req_valid, req_op, req_csr, req_rd, req_src, req_wsup,
        input  req_ready, done, illegal
    );

    modport slave (
        input  req_valid, req_op, req_csr, req_rd, req_src, req_wsup,
        output req_ready, done, illegal
    );
endinterface

// File: rtl/fwrisc_csr_sequencer.sv
// fwrisc_csr_sequencer: sequences CSRRW/CSRRS/CSRRC onto the regfile rb read
// port and the single rd write port (GPRs 0x00-0x1F, CSRs 0x20-0x3F).
// Owns the rd write-port mux: pipeline writeback wins, but after MAX_STALL
// consecutive lost cycles the sequencer is forced through (wb_stall=1).
// Optional read-only CSR check: define FWRISC_CSR_RO_CHECK_EN.
module fwrisc_csr_sequencer #(
    parameter int unsigned MAX_STALL = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fwrisc_csr_sequencer_if.slave req,
    output logic [5:0]            rb_raddr,
    input  logic [31:0]           rb_rdata,
    input  logic                  wb_valid,
    input  logic [5:0]            wb_waddr,
    input  logic [31:0]           wb_wdata,
    output logic                  wb_stall,
    output logic [5:0]            rd_waddr,
    output logic [31:0]           rd_wdata,
    output logic                  rd_wen
);

    // Regfile-mapped CSR addresses (must match fwrisc_regfile's map)
    localparam logic [5:0] CSR_MSTATUS    = 6'h20;
    localparam logic [5:0] CSR_MISA       = 6'h21;
    localparam logic [5:0] CSR_MIE        = 6'h22;
    localparam logic [5:0] CSR_MTVEC      = 6'h23;
    localparam logic [5:0] CSR_MSCRATCH   = 6'h24;
    localparam logic [5:0] CSR_MEPC       = 6'h25;
    localparam logic [5:0] CSR_MCAUSE     = 6'h26;
    localparam logic [5:0] CSR_MTVAL      = 6'h27;
    localparam logic [5:0] CSR_MIP        = 6'h28;
    localparam logic [5:0] CSR_MVENDORID  = 6'h29;
    localparam logic [5:0] CSR_MARCHID    = 6'h2A;
    localparam logic [5:0] CSR_MIMPID     = 6'h2B;
    localparam logic [5:0] CSR_MHARTID    = 6'h2C;
    localparam logic [5:0] CSR_SOFT_RESET = 6'h2D;

    localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

    typedef enum logic [2:0] {IDLE, READ, WCSR, WRD, DONE} state_t;

    state_t      state_reg;
    logic        ready_reg;
    logic        done_reg;
    logic [5:0]  rb_raddr_reg;
    logic [1:0]  op_reg;
    logic [5:0]  csr_reg;
    logic [5:0]  rd_reg;
    logic [31:0] src_reg;
    logic        wsup_reg;
    logic [31:0] old_reg;
    logic [3:0]  stall_cnt_reg;

    logic        seq_req;
    logic        seq_force;
    logic        seq_grant;
    logic        wb_write;
    logic [31:0] csr_new;

`ifdef FWRISC_CSR_RO_CHECK_EN
    localparam logic [5:0] RO_LIST [6] = '{CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID,
                                           CSR_MHARTID, CSR_MISA, CSR_MIP};
    logic [5:0] ro_hit;
    logic       illegal_reg;

    // One comparator per read-only CSR against the latched address
    for (genvar gi = 0; gi < 6; gi++) begin : g_ro
        assign ro_hit[gi] = (csr_reg == RO_LIST[gi]);
    end

    assign req.illegal = illegal_reg;
`else
    assign req.illegal = 1'b0;
`endif

    assign req.req_ready = ready_reg;
    assign req.done      = done_reg;
    assign rb_raddr      = rb_raddr_reg;

    // Write-port arbitration; reset kills any pending sequencer write at once
    always_comb begin
        seq_req   = !reset && ((state_reg == WCSR) || ((state_reg == WRD) && (rd_reg != 6'd0)));
        seq_force = seq_req && (stall_cnt_reg >= MAX_CNT);
        seq_grant = seq_req && (!wb_valid || seq_force);
        wb_write  = wb_valid && !seq_force;
        wb_stall  = wb_valid && seq_force;
    end

    // CSR read-modify-write value; op 00 behaves as RW
    always_comb begin
        csr_new = src_reg;
        case (op_reg)
            2'b10:   csr_new = old_reg | src_reg;
            2'b11:   csr_new = old_reg & ~src_reg;
            default: csr_new = src_reg;
        endcase
    end

    // rd write-port mux: granted sequencer write, else pipeline pass-through
    always_comb begin
        rd_wen   = 1'b0;
        rd_waddr = 6'd0;
        rd_wdata = 32'd0;
        if (seq_grant) begin
            rd_wen = 1'b1;
            if (state_reg == WCSR) begin
                rd_waddr = csr_reg;
                rd_wdata = csr_new;
            end else begin
                rd_waddr = rd_reg;
                rd_wdata = old_reg;
            end
        end else if (wb_write) begin
            rd_wen   = 1'b1;
            rd_waddr = wb_waddr;
            rd_wdata = wb_wdata;
        end
    end

    // Bounded-starvation counter: counts cycles the sequencer lost arbitration
    always_ff @(posedge clock) begin
        if (reset || (state_reg == IDLE) || seq_grant) begin
            stall_cnt_reg <= 4'd0;
        end else if (seq_req && wb_valid) begin
            stall_cnt_reg <= stall_cnt_reg + 4'd1;
        end
    end

    // Sequencer FSM with registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b1;
            done_reg     <= 1'b0;
            rb_raddr_reg <= 6'd0;
            op_reg       <= 2'd0;
            csr_reg      <= 6'd0;
            rd_reg       <= 6'd0;
            src_reg      <= 32'd0;
            wsup_reg     <= 1'b0;
            old_reg      <= 32'd0;
`ifdef FWRISC_CSR_RO_CHECK_EN
            illegal_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req.req_valid) begin
                        op_reg       <= req.req_op;
                        csr_reg      <= req.req_csr;
                        rd_reg       <= req.req_rd;
                        src_reg      <= req.req_src;
                        wsup_reg     <= req.req_wsup;
                        rb_raddr_reg <= req.req_csr;
                        ready_reg    <= 1'b0;
                        state_reg    <= READ;
                    end
                end
                READ: begin
                    old_reg      <= rb_rdata;
                    rb_raddr_reg <= 6'd0;
                    if (wsup_reg) begin
                        state_reg <= WRD;
                    end
`ifdef FWRISC_CSR_RO_CHECK_EN
                    else if (|ro_hit) begin
                        illegal_reg <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
`endif
                    else begin
                        state_reg <= WCSR;
                    end
                end
                WCSR: begin
                    if (seq_grant) begin
                        state_reg <= WRD;
                    end
                end
                WRD: begin
                    if ((rd_reg == 6'd0) || seq_grant) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
`ifdef FWRISC_CSR_RO_CHECK_EN
                    illegal_reg <= 1'b0;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
